// File: rtl/id_register_file.sv
// ID-stage register file with write-first WB bypass.
// Read operands are registered at the ID/EX boundary.
module id_register_file #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              RegWrite_WB,
  input  logic [ADDR_W-1:0] Write_Reg_WB,
  input  logic [DATA_W-1:0] Write_Data_WB,
  input  logic [ADDR_W-1:0] Read_Reg1_ID,
  input  logic [ADDR_W-1:0] Read_Reg2_ID,
  input  logic              Stall_ID,
  input  logic              Flush_ID,
  output logic [DATA_W-1:0] Read_Data1_EX,
  output logic [DATA_W-1:0] Read_Data2_EX
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_regs [DEPTH];
  logic [DATA_W-1:0] r_rd1;
  logic [DATA_W-1:0] r_rd2;

  logic              w_we;
  logic              w_wa_ok;
  logic [DATA_W-1:0] w_rd1_nxt;
  logic [DATA_W-1:0] w_rd2_nxt;

  // Indices beyond NUM_REGS behave like r0: never stored, read as zero.
  function automatic logic idx_ok(input logic [ADDR_W-1:0] idx);
    return (idx != '0) && (int'(idx) < NUM_REGS);
  endfunction

  function automatic logic [DATA_W-1:0] rd_sel(
    input logic [ADDR_W-1:0] idx,
    input logic              we,
    input logic [ADDR_W-1:0] wa,
    input logic [DATA_W-1:0] wd,
    input logic [DATA_W-1:0] stored
  );
    logic [DATA_W-1:0] v;
    v = '0;
    if (!idx_ok(idx))
      v = '0;
    else if (we && (wa == idx))
      v = wd;
    else
      v = stored;
    return v;
  endfunction

  assign w_wa_ok = idx_ok(Write_Reg_WB);
  assign w_we    = RegWrite_WB && w_wa_ok;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < DEPTH; i++)
        r_regs[i] <= '0;
    end else if (w_we) begin
      r_regs[Write_Reg_WB] <= Write_Data_WB;
    end
  end

  always_comb begin
    w_rd1_nxt = '0;
    w_rd2_nxt = '0;
    w_rd1_nxt = rd_sel(Read_Reg1_ID, w_we, Write_Reg_WB,
                       Write_Data_WB, r_regs[Read_Reg1_ID]);
    w_rd2_nxt = rd_sel(Read_Reg2_ID, w_we, Write_Reg_WB,
                       Write_Data_WB, r_regs[Read_Reg2_ID]);
  end

  // Flush beats stall so a bubble can be forced into a held slot.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_rd1 <= '0;
      r_rd2 <= '0;
    end else if (Flush_ID) begin
      r_rd1 <= '0;
      r_rd2 <= '0;
    end else if (!Stall_ID) begin
      r_rd1 <= w_rd1_nxt;
      r_rd2 <= w_rd2_nxt;
    end
  end

  assign Read_Data1_EX = r_rd1;
  assign Read_Data2_EX = r_rd2;

endmodule

// File: tb/tb_id_register_file.sv
// Self-checking bench for id_register_file.
// Table vectors plus reset sequences, checked through a queue.
module tb_id_register_file;

  logic        Clk;
  logic        Reset_n;
  logic        RegWrite_WB;
  logic [4:0]  Write_Reg_WB;
  logic [31:0] Write_Data_WB;
  logic [4:0]  Read_Reg1_ID;
  logic [4:0]  Read_Reg2_ID;
  logic        Stall_ID;
  logic        Flush_ID;
  logic [31:0] Read_Data1_EX;
  logic [31:0] Read_Data2_EX;

  id_register_file #(
    .DATA_W(32), .ADDR_W(5), .NUM_REGS(32)
  ) dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .RegWrite_WB  (RegWrite_WB),
    .Write_Reg_WB (Write_Reg_WB),
    .Write_Data_WB(Write_Data_WB),
    .Read_Reg1_ID (Read_Reg1_ID),
    .Read_Reg2_ID (Read_Reg2_ID),
    .Stall_ID     (Stall_ID),
    .Flush_ID     (Flush_ID),
    .Read_Data1_EX(Read_Data1_EX),
    .Read_Data2_EX(Read_Data2_EX)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic        stall;
    logic        flush;
    logic [31:0] e1;
    logic [31:0] e2;
    string       name;
  } vec_t;

  typedef struct {
    logic [31:0] e1;
    logic [31:0] e2;
    string       name;
  } exp_t;

  vec_t vecs[19];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    RegWrite_WB   = v.we;
    Write_Reg_WB  = v.wa;
    Write_Data_WB = v.wd;
    Read_Reg1_ID  = v.ra1;
    Read_Reg2_ID  = v.ra2;
    Stall_ID      = v.stall;
    Flush_ID      = v.flush;
  endtask

  // Drive one cycle, queue its expectation, compare after the edge.
  task automatic apply(input vec_t v);
    exp_t e;
    drive(v);
    e.e1 = v.e1;
    e.e2 = v.e2;
    e.name = v.name;
    sb.push_back(e);
    @(posedge Clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty", v.name);
    end else begin
      e = sb.pop_front();
      check({e.name, ".rd1"}, Read_Data1_EX, e.e1);
      check({e.name, ".rd2"}, Read_Data2_EX, e.e2);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [4:0] wa,
                              input logic [31:0] wd,
                              input logic [4:0] ra1, input logic [4:0] ra2,
                              input logic st, input logic fl,
                              input logic [31:0] e1, input logic [31:0] e2,
                              input string nm);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd;
    v.ra1 = ra1; v.ra2 = ra2;
    v.stall = st; v.flush = fl;
    v.e1 = e1; v.e2 = e2; v.name = nm;
    return v;
  endfunction

  vec_t idle;

  initial begin
    vecs[0]  = mk(1, 5,  32'hDEADBEEF, 0,  0,  0, 0, 32'h0, 32'h0, "wr_r5");
    vecs[1]  = mk(0, 0,  32'h0, 5,  5,  0, 0, 32'hDEADBEEF, 32'hDEADBEEF, "rd_r5");
    vecs[2]  = mk(1, 7,  32'h11111111, 5, 0, 0, 0, 32'hDEADBEEF, 32'h0, "wr_r7");
    vecs[3]  = mk(1, 7,  32'h22222222, 7, 7, 0, 0, 32'h22222222, 32'h22222222, "byp_r7");
    vecs[4]  = mk(0, 0,  32'h0, 7,  5,  0, 0, 32'h22222222, 32'hDEADBEEF, "rd_r7_r5");
    vecs[5]  = mk(1, 0,  32'hFFFFFFFF, 0, 0, 0, 0, 32'h0, 32'h0, "wr_r0");
    vecs[6]  = mk(0, 0,  32'h0, 0,  0,  0, 0, 32'h0, 32'h0, "rd_r0");
    vecs[7]  = mk(1, 10, 32'h0000ABCD, 0, 0, 0, 0, 32'h0, 32'h0, "wr_r10");
    vecs[8]  = mk(0, 0,  32'h0, 10, 10, 0, 0, 32'h0000ABCD, 32'h0000ABCD, "rd_r10");
    vecs[9]  = mk(1, 3,  32'h55, 3, 3, 1, 0, 32'h0000ABCD, 32'h0000ABCD, "stall1");
    vecs[10] = mk(1, 3,  32'h55, 3, 3, 1, 0, 32'h0000ABCD, 32'h0000ABCD, "stall2");
    vecs[11] = mk(1, 3,  32'h55, 3, 3, 1, 0, 32'h0000ABCD, 32'h0000ABCD, "stall3");
    vecs[12] = mk(0, 0,  32'h0, 3,  3,  0, 0, 32'h55, 32'h55, "release");
    vecs[13] = mk(0, 0,  32'h0, 3,  3,  1, 1, 32'h0, 32'h0, "stall_flush");
    vecs[14] = mk(1, 5,  32'h1, 5,  5,  0, 1, 32'h0, 32'h0, "flush_wr");
    vecs[15] = mk(0, 0,  32'h0, 5,  7,  0, 0, 32'h1, 32'h22222222, "rd_after_flush");
    vecs[16] = mk(1, 31, 32'hA5A5A5A5, 31, 30, 0, 0, 32'hA5A5A5A5, 32'h0, "byp_one_port");
    vecs[17] = mk(0, 0,  32'h0, 31, 31, 1, 0, 32'hA5A5A5A5, 32'h0, "stall_hold");
    vecs[18] = mk(0, 31, 32'h12345678, 31, 31, 0, 0, 32'hA5A5A5A5, 32'hA5A5A5A5, "no_we_no_byp");
    idle = mk(0, 0, 32'h0, 0, 0, 0, 0, 32'h0, 32'h0, "idle");

    Reset_n = 1'b0;
    drive(idle);
    repeat (2) @(posedge Clk);
    #1;
    check("reset.rd1", Read_Data1_EX, 32'h0);
    check("reset.rd2", Read_Data2_EX, 32'h0);
    @(negedge Clk);
    Reset_n = 1'b1;

    for (int i = 0; i < 19; i++)
      apply(vecs[i]);

    // Asynchronous reset mid-cycle with nonzero outputs.
    #2;
    Reset_n = 1'b0;
    #1;
    check("async_rst.rd1", Read_Data1_EX, 32'h0);
    check("async_rst.rd2", Read_Data2_EX, 32'h0);
    @(posedge Clk);
    @(negedge Clk);
    Reset_n = 1'b1;
    for (int r = 1; r < 32; r++)
      apply(mk(0, 0, 32'h0, 5'(r), 5'(32 - r), 0, 0,
               32'h0, 32'h0, $sformatf("sweep_r%0d", r)));

    // Reset in the middle of operation clears stored data.
    apply(mk(1, 9, 32'h99, 0, 0, 0, 0, 32'h0, 32'h0, "wr_r9"));
    apply(mk(0, 0, 32'h0, 9, 9, 0, 0, 32'h99, 32'h99, "rd_r9"));
    @(negedge Clk);
    Reset_n = 1'b0;
    @(negedge Clk);
    Reset_n = 1'b1;
    apply(mk(0, 0, 32'h0, 9, 9, 0, 0, 32'h0, 32'h0, "rd_r9_after_rst"));

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_leftover: got %0d expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
